// File: rtl/vx_tex_csr_bank.sv
// vx_tex_csr_bank: texture CSR write decoder with per-stage state and registered lookup port
module vx_tex_csr_bank #(
  parameter int CSR_ADDR_BITS = 12,
  parameter int UUID_BITS = 44,
  parameter logic [CSR_ADDR_BITS-1:0] CSR_BASE = 12'h7C0,
  parameter int NUM_STAGES = 2,
  parameter int NUM_LODS = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            write_enable,
  input  logic [CSR_ADDR_BITS-1:0]        write_addr,
  input  logic [31:0]                     write_data,
  input  logic [UUID_BITS-1:0]            write_uuid,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [$clog2(NUM_STAGES):0]     req_stage,
  input  logic [TAG_WIDTH-1:0]            req_tag,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [TAG_WIDTH-1:0]            rsp_tag,
  output logic                            rsp_err,
  output logic [31:0]                     rsp_addr,
  output logic [7:0]                      rsp_logdim,
  output logic [2:0]                      rsp_format,
  output logic [3:0]                      rsp_wrap,
  output logic                            rsp_filter,
  output logic [NUM_LODS*32-1:0]          rsp_mipoff,
  output logic                            csr_err,
  output logic [UUID_BITS-1:0]            last_uuid
);
  localparam int SW = $clog2(NUM_STAGES) + 1;
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  logic [IW-1:0] stage_q;
  logic [31:0] addr_q [NUM_STAGES];
  logic [7:0] logdim_q [NUM_STAGES];
  logic [2:0] format_q [NUM_STAGES];
  logic [3:0] wrap_q [NUM_STAGES];
  logic filter_q [NUM_STAGES];
  logic [NUM_LODS*32-1:0] mip_q [NUM_STAGES];
  logic [CSR_ADDR_BITS-1:0] off;
  logic hit, acc, in_rng;
  logic [IW-1:0] ridx;
  always_comb begin
    off = write_addr - CSR_BASE;
    hit = write_enable && (off < CSR_ADDR_BITS'(6 + NUM_LODS));
    req_ready = !rsp_valid || rsp_ready;
    acc = req_valid && req_ready;
    in_rng = req_stage < SW'(NUM_STAGES);
    ridx = req_stage[IW-1:0];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q <= '0;
      csr_err <= 1'b0;
      last_uuid <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        addr_q[i] <= '0;
        logdim_q[i] <= '0;
        format_q[i] <= '0;
        wrap_q[i] <= '0;
        filter_q[i] <= 1'b0;
        mip_q[i] <= '0;
      end
    end else if (hit) begin
      last_uuid <= write_uuid;
      if (off == '0) begin
        if (write_data < 32'(NUM_STAGES))
          stage_q <= write_data[IW-1:0];
        else
          csr_err <= 1'b1;
      end
      if (off == CSR_ADDR_BITS'(1)) addr_q[stage_q] <= write_data;
      if (off == CSR_ADDR_BITS'(2)) logdim_q[stage_q] <= write_data[7:0];
      if (off == CSR_ADDR_BITS'(3)) format_q[stage_q] <= write_data[2:0];
      if (off == CSR_ADDR_BITS'(4)) wrap_q[stage_q] <= write_data[3:0];
      if (off == CSR_ADDR_BITS'(5)) filter_q[stage_q] <= write_data[0];
      for (int k = 0; k < NUM_LODS; k++)
        if (off == CSR_ADDR_BITS'(6 + k)) mip_q[stage_q][k*32 +: 32] <= write_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_tag <= '0;
      rsp_err <= 1'b0;
      rsp_addr <= '0;
      rsp_logdim <= '0;
      rsp_format <= '0;
      rsp_wrap <= '0;
      rsp_filter <= 1'b0;
      rsp_mipoff <= '0;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_tag <= req_tag;
      rsp_err <= !in_rng;
      rsp_addr <= in_rng ? addr_q[ridx] : '0;
      rsp_logdim <= in_rng ? logdim_q[ridx] : '0;
      rsp_format <= in_rng ? format_q[ridx] : '0;
      rsp_wrap <= in_rng ? wrap_q[ridx] : '0;
      rsp_filter <= in_rng ? filter_q[ridx] : 1'b0;
      rsp_mipoff <= in_rng ? mip_q[ridx] : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vx_tex_csr_bank.sv
// tb_vx_tex_csr_bank: table vectors, corner sequences and randomized checks against a field-level model
module tb_vx_tex_csr_bank;
  localparam int NS = 2;
  localparam int NL = 4;
  localparam int BASE = 'h7C0;
  typedef struct {
    logic we; int off; logic [31:0] wd; logic [43:0] wu;
    logic rv; logic [1:0] st; logic [7:0] tg;
    logic ev; logic [7:0] et; logic ee; logic [31:0] ea; logic [7:0] el;
    logic [2:0] ef; logic [31:0] em; logic ec; logic [43:0] eu;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic write_enable = 1'b0;
  logic [11:0] write_addr = '0;
  logic [31:0] write_data = '0;
  logic [43:0] write_uuid = '0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_stage = '0;
  logic [7:0] req_tag = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [7:0] rsp_tag;
  logic rsp_err;
  logic [31:0] rsp_addr;
  logic [7:0] rsp_logdim;
  logic [2:0] rsp_format;
  logic [3:0] rsp_wrap;
  logic rsp_filter;
  logic [127:0] rsp_mipoff;
  logic csr_err;
  logic [43:0] last_uuid;
  int n_vec = 0;
  int n_err = 0;
  int unsigned m_addr [NS], m_ld [NS], m_fmt [NS], m_wrap [NS], m_filt [NS];
  int unsigned m_mip [NS][NL];
  int m_stage;
  logic m_cerr;
  logic [43:0] m_uuid;
  logic m_valid, m_err, m_rfilt;
  logic [7:0] m_tag, m_rld;
  logic [31:0] m_raddr;
  logic [2:0] m_rfmt;
  logic [3:0] m_rwrap;
  logic [127:0] m_rmip;
  vec_t tbl [15];

  vx_tex_csr_bank dut (
    .clk(clk), .reset_n(reset_n), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .write_uuid(write_uuid), .req_valid(req_valid), .req_ready(req_ready),
    .req_stage(req_stage), .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_addr(rsp_addr), .rsp_logdim(rsp_logdim),
    .rsp_format(rsp_format), .rsp_wrap(rsp_wrap), .rsp_filter(rsp_filter), .rsp_mipoff(rsp_mipoff),
    .csr_err(csr_err), .last_uuid(last_uuid)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [127:0] a, logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endfunction

  function automatic vec_t mk(logic we, int off, logic [31:0] wd, logic [43:0] wu, logic rv,
      logic [1:0] st, logic [7:0] tg, logic ev, logic [7:0] et, logic ee, logic [31:0] ea,
      logic [7:0] el, logic [2:0] ef, logic [31:0] em, logic ec, logic [43:0] eu);
    vec_t v;
    v.we = we; v.off = off; v.wd = wd; v.wu = wu; v.rv = rv; v.st = st; v.tg = tg;
    v.ev = ev; v.et = et; v.ee = ee; v.ea = ea; v.el = el; v.ef = ef; v.em = em; v.ec = ec; v.eu = eu;
    return v;
  endfunction

  task automatic tick();
    bit acc;
    int o;
    acc = req_valid && (!m_valid || rsp_ready);
    if (!reset_n) begin
      m_stage = 0; m_cerr = 0; m_uuid = '0;
      m_valid = 0; m_tag = '0; m_err = 0; m_raddr = '0; m_rld = '0;
      m_rfmt = '0; m_rwrap = '0; m_rfilt = 0; m_rmip = '0;
      for (int s = 0; s < NS; s++) begin
        m_addr[s] = 0; m_ld[s] = 0; m_fmt[s] = 0; m_wrap[s] = 0; m_filt[s] = 0;
        for (int k = 0; k < NL; k++) m_mip[s][k] = 0;
      end
    end else begin
      if (acc) begin
        m_valid = 1;
        m_tag = req_tag;
        m_err = int'(req_stage) >= NS;
        m_raddr = '0; m_rld = '0; m_rfmt = '0; m_rwrap = '0; m_rfilt = 0; m_rmip = '0;
        if (!m_err) begin
          m_raddr = m_addr[req_stage];
          m_rld = 8'(m_ld[req_stage]);
          m_rfmt = 3'(m_fmt[req_stage]);
          m_rwrap = 4'(m_wrap[req_stage]);
          m_rfilt = m_filt[req_stage] != 0;
          for (int k = 0; k < NL; k++) m_rmip[k*32 +: 32] = m_mip[req_stage][k];
        end
      end else if (rsp_ready) m_valid = 0;
      o = int'(write_addr) - BASE;
      if (write_enable && o >= 0 && o < 6 + NL) begin
        m_uuid = write_uuid;
        case (o)
          0: if (write_data < NS) m_stage = int'(write_data); else m_cerr = 1;
          1: m_addr[m_stage] = write_data;
          2: m_ld[m_stage] = write_data % 256;
          3: m_fmt[m_stage] = write_data % 8;
          4: m_wrap[m_stage] = write_data % 16;
          5: m_filt[m_stage] = write_data % 2;
          default: m_mip[m_stage][o-6] = write_data;
        endcase
      end
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", rsp_valid, m_valid);
    chk("req_ready", req_ready, !m_valid || rsp_ready);
    chk("rsp_tag", rsp_tag, m_tag);
    chk("rsp_err", rsp_err, m_err);
    chk("rsp_addr", rsp_addr, m_raddr);
    chk("rsp_logdim", rsp_logdim, m_rld);
    chk("rsp_format", rsp_format, m_rfmt);
    chk("rsp_wrap", rsp_wrap, m_rwrap);
    chk("rsp_filter", rsp_filter, m_rfilt);
    chk("rsp_mipoff", rsp_mipoff, m_rmip);
    chk("csr_err", csr_err, m_cerr);
    chk("last_uuid", last_uuid, m_uuid);
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 32'h8000_1000, 44'hA01, 0, 0, 0,  0, 0,  0, 32'h0,         8'h00, 0, 32'h0,   0, 44'hA01);
    tbl[1]  = mk(0, 0, 0,             0,       1, 0, 5,  1, 5,  0, 32'h8000_1000, 8'h00, 0, 32'h0,   0, 44'hA01);
    tbl[2]  = mk(1, 0, 1,             44'hA03, 0, 0, 0,  0, 5,  0, 32'h8000_1000, 8'h00, 0, 32'h0,   0, 44'hA03);
    tbl[3]  = mk(1, 2, 32'h98,        44'hA04, 0, 0, 0,  0, 5,  0, 32'h8000_1000, 8'h00, 0, 32'h0,   0, 44'hA04);
    tbl[4]  = mk(1, 8, 32'h400,       44'hA05, 0, 0, 0,  0, 5,  0, 32'h8000_1000, 8'h00, 0, 32'h0,   0, 44'hA05);
    tbl[5]  = mk(0, 0, 0,             0,       1, 1, 6,  1, 6,  0, 32'h0,         8'h98, 0, 32'h400, 0, 44'hA05);
    tbl[6]  = mk(0, 0, 0,             0,       1, 0, 7,  1, 7,  0, 32'h8000_1000, 8'h00, 0, 32'h0,   0, 44'hA05);
    tbl[7]  = mk(1, 0, 7,             44'hA08, 0, 0, 0,  0, 7,  0, 32'h8000_1000, 8'h00, 0, 32'h0,   1, 44'hA08);
    tbl[8]  = mk(1, 10, 32'hDEAD,     44'hA09, 0, 0, 0,  0, 7,  0, 32'h8000_1000, 8'h00, 0, 32'h0,   1, 44'hA08);
    tbl[9]  = mk(1, 2, 32'h11,        44'hA0A, 0, 0, 0,  0, 7,  0, 32'h8000_1000, 8'h00, 0, 32'h0,   1, 44'hA0A);
    tbl[10] = mk(0, 0, 0,             0,       1, 1, 8,  1, 8,  0, 32'h0,         8'h11, 0, 32'h400, 1, 44'hA0A);
    tbl[11] = mk(1, 0, 0,             44'hA0C, 0, 0, 0,  0, 8,  0, 32'h0,         8'h11, 0, 32'h400, 1, 44'hA0C);
    tbl[12] = mk(1, 3, 32'hFFFF_FFFB, 44'hA0D, 1, 0, 9,  1, 9,  0, 32'h8000_1000, 8'h00, 0, 32'h0,   1, 44'hA0D);
    tbl[13] = mk(0, 0, 0,             0,       1, 0, 10, 1, 10, 0, 32'h8000_1000, 8'h00, 3, 32'h0,   1, 44'hA0D);
    tbl[14] = mk(0, 0, 0,             0,       1, 2, 11, 1, 11, 1, 32'h0,         8'h00, 0, 32'h0,   1, 44'hA0D);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      write_enable = tbl[i].we;
      write_addr = 12'(BASE + tbl[i].off);
      write_data = tbl[i].wd;
      write_uuid = tbl[i].wu;
      req_valid = tbl[i].rv;
      req_stage = tbl[i].st;
      req_tag = tbl[i].tg;
      rsp_ready = 1'b1;
      tick();
      chk($sformatf("t%0d.valid", i), rsp_valid, tbl[i].ev);
      chk($sformatf("t%0d.tag", i), rsp_tag, tbl[i].et);
      chk($sformatf("t%0d.err", i), rsp_err, tbl[i].ee);
      chk($sformatf("t%0d.addr", i), rsp_addr, tbl[i].ea);
      chk($sformatf("t%0d.logdim", i), rsp_logdim, tbl[i].el);
      chk($sformatf("t%0d.format", i), rsp_format, tbl[i].ef);
      chk($sformatf("t%0d.mip2", i), rsp_mipoff[95:64], tbl[i].em);
      chk($sformatf("t%0d.csr_err", i), csr_err, tbl[i].ec);
      chk($sformatf("t%0d.uuid", i), last_uuid, tbl[i].eu);
    end
    write_enable = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_stage = 2'd0;
    for (int i = 0; i < 3; i++) begin
      req_tag = 8'(20 + i);
      tick();
      chk("bp.req_ready", req_ready, 1'b0);
      chk("bp.rsp_tag", rsp_tag, 8'd11);
      chk("bp.rsp_err", rsp_err, 1'b1);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_tag = 8'(23 + i);
      tick();
      chk("rel.rsp_valid", rsp_valid, 1'b1);
      chk("rel.rsp_tag", rsp_tag, 8'(23 + i));
      chk("rel.rsp_format", rsp_format, 3'd3);
    end
    reset_n = 1'b0;
    tick();
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.rsp_tag", rsp_tag, 8'd0);
    chk("rst.csr_err", csr_err, 1'b0);
    reset_n = 1'b1;
    req_valid = 1'b0;
    tick();
    chk("rst.no_replay", rsp_valid, 1'b0);
    for (int i = 0; i < 600; i++) begin
      reset_n = $urandom_range(0, 63) != 0;
      write_enable = $urandom_range(0, 1) == 1;
      write_addr = 12'(BASE - 2 + int'($urandom_range(0, 13)));
      write_data = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 3)) : $urandom;
      write_uuid = {12'($urandom), 32'($urandom)};
      req_valid = $urandom_range(0, 2) != 0;
      req_stage = 2'($urandom_range(0, 3));
      req_tag = 8'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
